// File: rtl/clock_pkg.sv
// clock_pkg
// Shared types and helpers for the calendar clock:
//   field_e        - field codes used by field_sel / load_field
//   state_e        - set-flow controller states
//   *_MIN / *_MAX  - legal value range of every editable field
//   days_in_month  - month length with Gregorian leap-year rule,
//                    shared by the controller and the calendar counter
//   next_field     - edit order YEAR -> MONTH -> DAY -> HOUR -> MIN -> SEC
package clock_pkg;

    typedef enum logic [2:0] {
        F_SEC   = 3'd0,
        F_MIN   = 3'd1,
        F_HOUR  = 3'd2,
        F_DAY   = 3'd3,
        F_MONTH = 3'd4,
        F_YEAR  = 3'd5
    } field_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [13:0] SEC_MIN   = 14'd0;
    localparam logic [13:0] SEC_MAX   = 14'd59;
    localparam logic [13:0] MIN_MIN   = 14'd0;
    localparam logic [13:0] MIN_MAX   = 14'd59;
    localparam logic [13:0] HOUR_MIN  = 14'd0;
    localparam logic [13:0] HOUR_MAX  = 14'd23;
    localparam logic [13:0] DAY_MIN   = 14'd1;
    localparam logic [13:0] MONTH_MIN = 14'd1;
    localparam logic [13:0] MONTH_MAX = 14'd12;
    localparam logic [13:0] YEAR_MIN  = 14'd0;
    localparam logic [13:0] YEAR_MAX  = 14'd9999;

    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [13:0] year);
        logic leap;
        leap = (((year % 14'd4) == 14'd0) && ((year % 14'd100) != 14'd0)) ||
               ((year % 14'd400) == 14'd0);
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    function automatic field_e next_field(input field_e f);
        case (f)
            F_YEAR:  next_field = F_MONTH;
            F_MONTH: next_field = F_DAY;
            F_DAY:   next_field = F_HOUR;
            F_HOUR:  next_field = F_MIN;
            F_MIN:   next_field = F_SEC;
            default: next_field = F_YEAR;
        endcase
    endfunction

endpackage

// File: rtl/clock_tick_gen.sv
// clock_tick_gen
// Prescaler producing the one-cycle 1 Hz advance tick and the display blink
// phase. Optional feature macro: CLOCK_SET_BLINK_EN (blink phase generation).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_clear     - force prescaler to 0 (priority over counting)
//   i_count     - advance prescaler this cycle
//   i_tick_en   - allow a tick to be emitted on wrap
//   i_blink_en  - allow blink output (editing phases only)
//   o_tick      - registered one-cycle tick
//   o_blink     - registered blank phase (upper half of the prescaler period)
module clock_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    input  logic i_tick_en,
    input  logic i_blink_en,
    output logic o_tick,
    output logic o_blink
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
`ifdef CLOCK_SET_BLINK_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
`endif

    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          w_wrap;
    logic          w_blink_phase;
    logic          r_tick;
    logic          r_blink;

    // Next prescaler value; clear wins over counting.
    always_comb begin
        w_wrap = (r_presc == PRESC_MAX);
        if (i_clear) begin
            w_presc_next = {PW{1'b0}};
        end else if (i_count) begin
            w_presc_next = w_wrap ? {PW{1'b0}} : (r_presc + PW'(1));
        end else begin
            w_presc_next = r_presc;
        end
`ifdef CLOCK_SET_BLINK_EN
        // Phase taken from the next value so blink lines up with the register.
        w_blink_phase = (w_presc_next >= PRESC_HALF);
`else
        w_blink_phase = 1'b0;
`endif
    end

    // Prescaler, tick and blink registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= {PW{1'b0}};
            r_tick  <= 1'b0;
            r_blink <= 1'b0;
        end else begin
            r_presc <= w_presc_next;
            r_tick  <= i_tick_en && i_count && !i_clear && w_wrap;
            r_blink <= i_blink_en && w_blink_phase;
        end
    end

    assign o_tick  = r_tick;
    assign o_blink = r_blink;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Sequences the calendar counter: 1 Hz tick in RUN and a button-driven
// time/date setting flow (EDIT/COMMIT) that loads fields over valid/ready.
// Optional feature macro: CLOCK_SET_BLINK_EN (blinking edited field).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   i_btn_mode/inc/dec         - single-cycle debounced button pulses
//   i_cur_sec..i_cur_year      - live counter values
//   o_tick                     - one-cycle advance enable
//   o_set_active               - high outside RUN
//   o_field_sel, o_edit_val    - field being edited and its value
//   o_load_valid/field/value   - load request to the counter
//   i_load_ready               - counter accepts the load
//   o_blink                    - display blank phase
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_btn_mode,
    input  logic        i_btn_inc,
    input  logic        i_btn_dec,
    input  logic [5:0]  i_cur_sec,
    input  logic [5:0]  i_cur_min,
    input  logic [4:0]  i_cur_hour,
    input  logic [4:0]  i_cur_day,
    input  logic [3:0]  i_cur_month,
    input  logic [13:0] i_cur_year,
    output logic        o_tick,
    output logic        o_set_active,
    output logic [2:0]  o_field_sel,
    output logic [13:0] o_edit_val,
    output logic        o_load_valid,
    output logic [2:0]  o_load_field,
    output logic [13:0] o_load_value,
    input  logic        i_load_ready,
    output logic        o_blink
);
    state_e      r_state;
    field_e      r_field;
    logic [13:0] r_edit_val;
    logic        r_capture;     // next EDIT cycle loads edit_val from cur_*
    logic        r_set_active;
    logic        r_load_valid;
    logic [2:0]  r_load_field;
    logic [13:0] r_load_value;

    logic [4:0]  w_dim;
    logic [13:0] w_lo;
    logic [13:0] w_hi;
    logic [13:0] w_inc_val;
    logic [13:0] w_dec_val;
    logic [13:0] w_capture_val;
    logic        w_transfer;
    logic        w_adjust;
    logic        w_clear;
    logic        w_count;
    logic        w_tick_en;
    logic        w_blink_en;

    // Field range and wrapped +/-1 values for the field being edited.
    always_comb begin
        w_dim = days_in_month(i_cur_month, i_cur_year);
        case (r_field)
            F_SEC:   begin w_lo = SEC_MIN;   w_hi = SEC_MAX;        end
            F_MIN:   begin w_lo = MIN_MIN;   w_hi = MIN_MAX;        end
            F_HOUR:  begin w_lo = HOUR_MIN;  w_hi = HOUR_MAX;       end
            F_DAY:   begin w_lo = DAY_MIN;   w_hi = {9'd0, w_dim};  end
            F_MONTH: begin w_lo = MONTH_MIN; w_hi = MONTH_MAX;      end
            F_YEAR:  begin w_lo = YEAR_MIN;  w_hi = YEAR_MAX;       end
            default: begin w_lo = 14'd0;     w_hi = 14'd0;          end
        endcase
        w_inc_val = (r_edit_val >= w_hi) ? w_lo : (r_edit_val + 14'd1);
        w_dec_val = (r_edit_val <= w_lo) ? w_hi : (r_edit_val - 14'd1);
    end

    // Live value of the current field; day is clamped to the month length.
    always_comb begin
        case (r_field)
            F_SEC:   w_capture_val = {8'd0, i_cur_sec};
            F_MIN:   w_capture_val = {8'd0, i_cur_min};
            F_HOUR:  w_capture_val = {9'd0, i_cur_hour};
            F_DAY:   w_capture_val = (i_cur_day > w_dim) ? {9'd0, w_dim} : {9'd0, i_cur_day};
            F_MONTH: w_capture_val = {10'd0, i_cur_month};
            F_YEAR:  w_capture_val = i_cur_year;
            default: w_capture_val = 14'd0;
        endcase
    end

    // Prescaler control: cleared on leaving and re-entering RUN.
    always_comb begin
        w_transfer = (r_state == ST_COMMIT) && i_load_ready;
        w_adjust   = (r_state == ST_EDIT) && !r_capture && !i_btn_mode &&
                     (i_btn_inc != i_btn_dec);
        w_tick_en  = (r_state == ST_RUN) && !i_btn_mode;
        w_blink_en = (r_state != ST_RUN);
`ifdef CLOCK_SET_BLINK_EN
        // Any edit restarts the phase so the new value is visible at once.
        w_clear = ((r_state == ST_RUN) && i_btn_mode) ||
                  (w_transfer && (r_field == F_SEC)) || w_adjust;
        w_count = 1'b1;
`else
        w_clear = ((r_state == ST_RUN) && i_btn_mode) ||
                  (w_transfer && (r_field == F_SEC));
        w_count = (r_state == ST_RUN);
`endif
    end

    clock_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_count    (w_count),
        .i_tick_en  (w_tick_en),
        .i_blink_en (w_blink_en),
        .o_tick     (o_tick),
        .o_blink    (o_blink)
    );

    // Setting-flow FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_field      <= F_YEAR;
            r_edit_val   <= 14'd0;
            r_capture    <= 1'b0;
            r_set_active <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_field <= 3'd0;
            r_load_value <= 14'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_btn_mode) begin
                        r_state      <= ST_EDIT;
                        r_set_active <= 1'b1;
                        r_field      <= F_YEAR;
                        r_edit_val   <= i_cur_year;
                        r_capture    <= 1'b0;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_EDIT: begin
                    if (r_capture) begin
                        // Counter has applied the previous load by now.
                        r_capture  <= 1'b0;
                        r_edit_val <= w_capture_val;
                    end else if (i_btn_mode) begin
                        r_state      <= ST_COMMIT;
                        r_load_valid <= 1'b1;
                        r_load_field <= r_field;
                        r_load_value <= r_edit_val;
                    end else if (i_btn_inc && !i_btn_dec) begin
                        r_edit_val <= w_inc_val;
                    end else if (i_btn_dec && !i_btn_inc) begin
                        r_edit_val <= w_dec_val;
                    end else begin
                        r_edit_val <= r_edit_val;
                    end
                end
                ST_COMMIT: begin
                    if (i_load_ready) begin
                        r_load_valid <= 1'b0;
                        if (r_field == F_SEC) begin
                            r_state      <= ST_RUN;
                            r_set_active <= 1'b0;
                            r_field      <= F_YEAR;
                        end else begin
                            r_state   <= ST_EDIT;
                            r_field   <= next_field(r_field);
                            r_capture <= 1'b1;
                        end
                    end else begin
                        r_load_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_set_active <= 1'b0;
                    r_load_valid <= 1'b0;
                    r_capture    <= 1'b0;
                end
            endcase
        end
    end

    assign o_set_active = r_set_active;
    assign o_field_sel  = r_field;
    assign o_edit_val   = r_edit_val;
    assign o_load_valid = r_load_valid;
    assign o_load_field = r_load_field;
    assign o_load_value = r_load_value;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
// Directed plus randomized stimulus for clock_set_ctrl (CLK_HZ=10) checked
// cycle by cycle against a behavioural reference model of the set flow.
module tb_clock_set_ctrl;
    localparam int HZ = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic [5:0]  cur_sec = 6'd0;
    logic [5:0]  cur_min = 6'd0;
    logic [4:0]  cur_hour = 5'd0;
    logic [4:0]  cur_day = 5'd1;
    logic [3:0]  cur_month = 4'd1;
    logic [13:0] cur_year = 14'd0;
    logic        load_ready = 1'b1;
    logic        tick, set_active, load_valid, blink;
    logic [2:0]  field_sel, load_field;
    logic [13:0] edit_val, load_value;

    clock_set_ctrl #(.CLK_HZ(HZ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_btn_mode   (btn_mode),
        .i_btn_inc    (btn_inc),
        .i_btn_dec    (btn_dec),
        .i_cur_sec    (cur_sec),
        .i_cur_min    (cur_min),
        .i_cur_hour   (cur_hour),
        .i_cur_day    (cur_day),
        .i_cur_month  (cur_month),
        .i_cur_year   (cur_year),
        .o_tick       (tick),
        .o_set_active (set_active),
        .o_field_sel  (field_sel),
        .o_edit_val   (edit_val),
        .o_load_valid (load_valid),
        .o_load_field (load_field),
        .o_load_value (load_value),
        .i_load_ready (load_ready),
        .o_blink      (blink)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0=running, 1=editing, 2=waiting for the load.
    // Fields are indexed in edit order 0=YEAR .. 5=SEC.
    int FCODE [6] = '{5, 4, 3, 2, 1, 0};
    int m_ph, m_fi, m_val, m_elapsed, m_cap;
    int e_tick, e_lv, e_lf, e_lval;

    function automatic int dim(input int mo, input int y);
        int len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        bit leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        if (mo == 2 && leap) return 29;
        return len[mo - 1];
    endfunction

    function automatic int lo_of(input int fi);
        return (fi == 1 || fi == 2) ? 1 : 0;
    endfunction

    function automatic int hi_of(input int fi);
        case (fi)
            0: return 9999;
            1: return 12;
            2: return dim(int'(cur_month), int'(cur_year));
            3: return 23;
            default: return 59;
        endcase
    endfunction

    function automatic int capture_val(input int fi);
        int d;
        case (fi)
            0: return int'(cur_year);
            1: return int'(cur_month);
            2: begin
                d = dim(int'(cur_month), int'(cur_year));
                return (int'(cur_day) > d) ? d : int'(cur_day);
            end
            3: return int'(cur_hour);
            4: return int'(cur_min);
            default: return int'(cur_sec);
        endcase
    endfunction

    function automatic int wrap(input int v, input int lo, input int hi);
        int span = hi - lo + 1;
        return lo + (((v - lo) % span) + span) % span;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_fi = 0; m_val = 0; m_elapsed = 0; m_cap = 0;
        e_tick = 0; e_lv = 0; e_lf = 0; e_lval = 0;
    endtask

    // Expected state after the coming clock edge, from the current inputs.
    task automatic model_step();
        e_tick = 0;
        case (m_ph)
            0: begin
                if (btn_mode) begin
                    m_ph = 1; m_fi = 0; m_val = int'(cur_year); m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == HZ) begin
                        m_elapsed = 0; e_tick = 1;
                    end
                end
            end
            1: begin
                if (m_cap != 0) begin
                    m_cap = 0; m_val = capture_val(m_fi);
                end else if (btn_mode) begin
                    m_ph = 2; e_lv = 1; e_lf = FCODE[m_fi]; e_lval = m_val;
                end else if (btn_inc && !btn_dec) begin
                    m_val = wrap(m_val + 1, lo_of(m_fi), hi_of(m_fi));
                end else if (btn_dec && !btn_inc) begin
                    m_val = wrap(m_val - 1, lo_of(m_fi), hi_of(m_fi));
                end
            end
            default: begin
                if (load_ready) begin
                    e_lv = 0;
                    if (m_fi == 5) begin
                        m_ph = 0; m_fi = 0; m_elapsed = 0;
                    end else begin
                        m_fi++; m_ph = 1; m_cap = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("tick",       32'(tick),       e_tick);
        check("set_active", 32'(set_active), (m_ph != 0) ? 1 : 0);
        check("field_sel",  32'(field_sel),  FCODE[m_fi]);
        check("edit_val",   32'(edit_val),   m_val);
        check("load_valid", 32'(load_valid), e_lv);
        check("load_field", 32'(load_field), e_lf);
        check("load_value", 32'(load_value), e_lval);
        check("blink",      32'(blink),      0);
    endtask

    task automatic step(input bit m, input bit i, input bit d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        model_step();
        @(posedge clk);
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        compare_all();
    endtask

    // Commit the current field with ready high, then let the next one capture.
    task automatic advance();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks;
        int saved;
        int first;
        int r;

        // Reset state.
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle RUN: ticks on cycles 10, 20, 30.
        ticks = 0;
        for (int c = 1; c <= 30; c++) begin
            step(1'b0, 1'b0, 1'b0);
            check("tick_idle", 32'(tick), (c % 10 == 0) ? 1 : 0);
            if (tick) ticks++;
        end
        check("tick_count_30", ticks, 3);

        // Year edit wrap from 9998.
        cur_year = 14'd9998;
        step(1'b1, 1'b0, 1'b0);
        check("year_enter", 32'(edit_val), 9998);
        step(1'b0, 1'b1, 1'b0);
        check("year_9999", 32'(edit_val), 9999);
        step(1'b0, 1'b1, 1'b0);
        check("year_wrap0", 32'(edit_val), 0);
        step(1'b0, 1'b1, 1'b0);
        check("year_1", 32'(edit_val), 1);

        // COMMIT held by load_ready low; inc ignored.
        load_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0);
            check("hold_valid", 32'(load_valid), 1);
            check("hold_value", 32'(load_value), 1);
        end
        load_ready = 1'b1;
        cur_month = 4'd2; cur_year = 14'd2100; cur_day = 5'd30;
        step(1'b0, 1'b0, 1'b0);
        check("accept_drop", 32'(load_valid), 0);
        step(1'b0, 1'b0, 1'b0);
        check("month_capture", 32'(edit_val), 2);

        // Day clamp in a non-leap February, then wrap to 1.
        advance();
        check("day_clamp_2100", 32'(edit_val), 28);
        step(1'b0, 1'b1, 1'b0);
        check("day_wrap", 32'(edit_val), 1);

        // Hour: dec, then mode+inc together leaves the value unchanged.
        cur_hour = 5'($urandom_range(0, 23));
        cur_min  = 6'($urandom_range(0, 59));
        cur_sec  = 6'($urandom_range(0, 59));
        advance();
        step(1'b0, 1'b0, 1'b1);
        saved = m_val;
        step(1'b1, 1'b1, 1'b0);
        check("mode_inc_value", 32'(load_value), saved);
        check("mode_inc_field", 32'(load_field), 2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        advance();
        step(1'b1, 1'b0, 1'b0);
        check("sec_commit_field", 32'(load_field), 0);
        step(1'b0, 1'b0, 1'b0);

        // Back in RUN: first tick 10 cycles after the SEC transfer.
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (tick && first == 0) first = k;
        end
        check("first_tick_rerun", first, 10);

        // Leap February 2000 clamps day to 29.
        cur_month = 4'd2; cur_year = 14'd2000; cur_day = 5'd30;
        step(1'b1, 1'b0, 1'b0);
        advance();
        advance();
        check("day_clamp_2000", 32'(edit_val), 29);

        // Randomized buttons, ready and live values.
        for (int n = 0; n < 600; n++) begin
            cur_sec  = 6'($urandom_range(0, 59));
            cur_min  = 6'($urandom_range(0, 59));
            cur_hour = 5'($urandom_range(0, 23));
            cur_day  = 5'($urandom_range(1, 31));
            load_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (r == 0)       step(1'b1, 1'b0, 1'b0);
            else if (r < 5)   step(1'b0, 1'b1, 1'b0);
            else if (r < 9)   step(1'b0, 1'b0, 1'b1);
            else if (r == 9)  step(1'b0, 1'b1, 1'b1);
            else if (r == 10) step(1'b1, 1'b0, 1'b1);
            else              step(1'b0, 1'b0, 1'b0);
        end

        // Return to RUN, then reset in the middle of a held COMMIT.
        load_ready = 1'b1;
        for (int k = 0; k < 60 && m_ph != 0; k++) begin
            if (m_ph == 1 && m_cap == 0) step(1'b1, 1'b0, 1'b0);
            else                         step(1'b0, 1'b0, 1'b0);
        end
        load_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("pre_reset_valid", 32'(load_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(load_valid), 0);
        check("async_active", 32'(set_active), 0);
        check("async_field", 32'(field_sel), 5);
        check("async_edit", 32'(edit_val), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        load_ready = 1'b1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (tick && first == 0) first = k;
        end
        check("first_tick_after_reset", first, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Controller that sequences the decade calendar counter. It generates the 1 Hz advance enable from the system clock, and runs the user time/date setting flow from three debounced buttons. Edited fields are pushed into the counter over a valid/ready load port. It sits between the button debouncers and the calendar counter, and drives the display's field-select and blink controls.

## Interface
- CLK_HZ, 50_000_000, clk cycles per second; ≥ 4
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- btn_mode / btn_inc / btn_dec  in  1 each  single-cycle debounced pulses
- cur_sec / cur_min  in  6 each  live counter values
- cur_hour / cur_day  in  5 each  live counter values
- cur_month  in  4  live value, 1..12
- cur_year  in  14  live value, 0..9999
- tick  out  1  one-cycle advance enable to counter
- set_active  out  1  high outside RUN
- field_sel  out  3  field being edited (package encoding)
- edit_val  out  14  value being edited, zero-extended
- load_valid  out  1  load request
- load_field  out  3  target field
- load_value  out  14  value to load
- load_ready  in  1  counter accepts load
- blink  out  1  display blank phase for the edited field

## Operation
- States: RUN, EDIT, COMMIT.
- Field order: YEAR → MONTH → DAY → HOUR → MIN → SEC.
- RUN:
  - Prescaler counts 0..CLK_HZ-1; tick=1 when prescaler==CLK_HZ-1.
  - btn_mode → EDIT with field=YEAR, edit_val←cur_year.
- EDIT:
  - tick is held 0.
  - btn_inc/btn_dec change edit_val by ±1 and wrap within the field range.
  - Ranges: SEC, MIN 0..59; HOUR 0..23; MONTH 1..12; YEAR 0..9999.
  - DAY range is 1..dim, where dim comes from cur_month/cur_year: 31/30 table; Feb 29 if (y%4==0 && y%100!=0) || y%400==0, else 28.
  - On entering DAY, if the captured cur_day > dim, edit_val is clamped to dim.
  - btn_mode → COMMIT.
- COMMIT:
  - load_valid=1; load_field and load_value are stable until transfer.
  - Transfer happens on the edge where load_valid && load_ready.
  - After a transfer, the next field is entered in EDIT and edit_val is captured from the matching cur_*.
  - After the SEC transfer, go to RUN and clear the prescaler to 0.
- Simultaneous pulses:
  - mode with inc or dec: mode wins and the inc/dec is dropped.
  - inc with dec: no change.
- All button pulses are ignored while in COMMIT.

## Timing
- Reset values: state=RUN, prescaler=0, tick=0, set_active=0, field_sel=YEAR, edit_val=0, load_valid=0, load_field=0, load_value=0, blink=0.
- Outputs are registered. tick rises the cycle after prescaler reaches CLK_HZ-1.
- First tick after reset, or after a RUN re-entry, comes CLK_HZ cycles later.
- State changes, and the resulting outputs, appear one cycle after the causing pulse.
- btn_mode in EDIT at edge N gives load_valid=1 from N+1.
- load_ready may be tied high; load_valid then lasts exactly one cycle per field.
- Transfer at edge T: load_valid=0 from T+1. The next field's edit_val is captured from cur_* sampled at edge T+1, so the counter must apply the load by T+1.
- rst_n low in any state (including mid-COMMIT) immediately forces the reset values. No partial load is retried.

## Configuration
- CLOCK_SET_BLINK_EN defined:
  - In EDIT/COMMIT the prescaler free-runs without generating tick.
  - blink=1 while prescaler ≥ CLK_HZ/2.
  - Any inc/dec clears the prescaler so the new value is shown immediately.
- Undefined: blink is constant 0; the prescaler holds at 0 outside RUN.

## Structure
- Package clock_pkg holds:
  - field enum field_e (F_SEC=0, F_MIN=1, F_HOUR=2, F_DAY=3, F_MONTH=4, F_YEAR=5), 3 bits
  - state enum
  - range constants
  - function days_in_month(month, year), shared with the counter
- Sub-module clock_tick_gen: prescaler, tick, and blink phase, with clear/run inputs.

## Test plan
- CLK_HZ=10, idle in RUN → tick on cycles 10, 20, 30 after reset release; set_active=0.
- btn_mode, then 3× btn_inc from cur_year=9998 → edit_val 9999, 0, 1; tick stays 0.
- cur_month=2, cur_year=2100, cur_day=30, enter DAY → edit_val=28; btn_inc → 1. With cur_year=2000 → clamp to 29.
- load_ready low for 5 cycles in COMMIT → load_valid held with stable field/value, btn_inc ignored, accepted on the cycle ready rises, next field loaded.
- Full sequence with load_ready=1 → six single-cycle loads in order YEAR..SEC, then RUN with the first tick 10 cycles later. Also: btn_mode+btn_inc in the same cycle → field advances, value unchanged.
- rst_n pulsed low while load_valid=1 → load_valid=0 asynchronously; state RUN, prescaler 0 after release.
